// File: rtl/vga_sched_pkg.sv
// Shared types for the VGA frame scheduler: FSM state encoding and the
// per-client pixel stream bundle.
package vga_sched_pkg;

  localparam int XW   = 8;  // VGA coordinate width
  localparam int CLRW = 3;  // VGA colour width

  typedef enum logic [2:0] {
    ST_MAP    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ERASE  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DRAW   = 3'd4
  } state_e;

  typedef struct packed {
    logic [XW-1:0]   x;
    logic [XW-1:0]   y;
    logic [CLRW-1:0] color;
    logic            plot;
  } pixel_t;

endpackage

// File: rtl/vga_client_mux.sv
// Combinational 3:1 pixel-stream mux: only the client owning the current
// phase reaches the VGA adapter; idle phases drive an all-zero pixel.
module vga_client_mux
  import vga_sched_pkg::*;
(
  input  state_e sel_i,
  input  pixel_t map_i,
  input  pixel_t erase_i,
  input  pixel_t draw_i,
  output pixel_t vga_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives vga_o and no latch is inferred.
    vga_o = '0;
    case (sel_i)
      ST_MAP:   vga_o = map_i;
      ST_ERASE: vga_o = erase_i;
      ST_DRAW:  vga_o = draw_i;
      default:  vga_o = '0;
    endcase
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Per-frame sequencer (MAP once, then ERASE/UPDATE/DRAW per tick) owning the
// VGA write port. Define VGA_SCHED_OVERRUN_COUNT_EN to add overrun_count.
module vga_frame_scheduler
  import vga_sched_pkg::*;
#(
  parameter int FRAME_DIV = 833333,
  parameter int TIMEOUT   = 65535,
  parameter int CW        = 20
) (
  input  logic            clock_50,
  input  logic            resetn,
  input  logic            en,
  output logic            map_start,
  output logic            erase_start,
  output logic            draw_start,
  input  logic            map_done,
  input  logic            erase_done,
  input  logic            draw_done,
  input  logic [XW-1:0]   map_x,
  input  logic [XW-1:0]   map_y,
  input  logic [CLRW-1:0] map_color,
  input  logic            map_plot,
  input  logic [XW-1:0]   erase_x,
  input  logic [XW-1:0]   erase_y,
  input  logic [CLRW-1:0] erase_color,
  input  logic            erase_plot,
  input  logic [XW-1:0]   draw_x,
  input  logic [XW-1:0]   draw_y,
  input  logic [CLRW-1:0] draw_color,
  input  logic            draw_plot,
  output logic            update_pulse,
  output logic [XW-1:0]   vga_x,
  output logic [XW-1:0]   vga_y,
  output logic [CLRW-1:0] vga_color,
  output logic            vga_plot,
  output logic            busy,
  output logic            overrun,
  output logic            timeout_err
`ifdef VGA_SCHED_OVERRUN_COUNT_EN
  ,
  output logic [7:0]      overrun_count
`endif
);

  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_DIV - 1);
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);

  state_e        state_q;
  logic          pend_q;
  logic [CW-1:0] frame_q, frame_d;
  logic [CW-1:0] timer_q;
  logic          map_start_q, erase_start_q, draw_start_q;
  logic          update_q, busy_q, overrun_q, timeout_q;

  logic tick, drop, in_start, done_sel, done_ok, expired, phase_end;
  state_e mux_sel;
  pixel_t map_px, erase_px, draw_px, vga_px;

  assign tick     = (frame_q == FRAME_LAST);
  assign drop     = tick && (state_q != ST_WAIT);
  assign frame_d  = tick ? '0 : frame_q + 1'b1;
  assign in_start = map_start_q | erase_start_q | draw_start_q;
  assign expired  = (timer_q == TIMER_LAST);

  always_comb begin
    done_sel = 1'b0;
    case (state_q)
      ST_MAP:   done_sel = map_done;
      ST_ERASE: done_sel = erase_done;
      ST_DRAW:  done_sel = draw_done;
      default:  done_sel = 1'b0;
    endcase
  end

  // Done is ignored in the start cycle; a coincident done wins over expiry.
  assign done_ok   = done_sel && !in_start;
  assign phase_end = !pend_q && (done_ok || expired);

  always_ff @(posedge clock_50) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (!resetn) frame_q <= '0;
    else         frame_q <= frame_d;
  end

  always_ff @(posedge clock_50) begin
    if (!resetn) begin
      state_q       <= ST_MAP;
      pend_q        <= 1'b1;
      timer_q       <= '0;
      map_start_q   <= 1'b0;
      erase_start_q <= 1'b0;
      draw_start_q  <= 1'b0;
      update_q      <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      map_start_q   <= 1'b0;
      erase_start_q <= 1'b0;
      draw_start_q  <= 1'b0;
      update_q      <= 1'b0;
      timer_q       <= timer_q + 1'b1;
      if (drop) overrun_q <= 1'b1;
      case (state_q)
        ST_MAP: begin
          if (pend_q) begin
            pend_q      <= 1'b0;
            map_start_q <= 1'b1;
            timer_q     <= '0;
            busy_q      <= 1'b1;
          end else if (phase_end) begin
            state_q <= ST_WAIT;
            busy_q  <= 1'b0;
            if (!done_ok) timeout_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (tick && en) begin
            state_q       <= ST_ERASE;
            erase_start_q <= 1'b1;
            timer_q       <= '0;
            busy_q        <= 1'b1;
          end
        end
        ST_ERASE: begin
          if (phase_end) begin
            state_q  <= ST_UPDATE;
            update_q <= 1'b1;
            if (!done_ok) timeout_q <= 1'b1;
          end
        end
        ST_UPDATE: begin
          state_q      <= ST_DRAW;
          draw_start_q <= 1'b1;
          timer_q      <= '0;
        end
        ST_DRAW: begin
          if (phase_end) begin
            state_q <= ST_WAIT;
            busy_q  <= 1'b0;
            if (!done_ok) timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_MAP;
          pend_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_SCHED_OVERRUN_COUNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clock_50) begin
    if (!resetn)                       ovr_cnt_q <= '0;
    else if (drop && ovr_cnt_q != '1)  ovr_cnt_q <= ovr_cnt_q + 1'b1;
  end

  assign overrun_count = ovr_cnt_q;
`endif

  // The pixel port stays quiet until MAP has actually been started.
  assign mux_sel  = pend_q ? ST_WAIT : state_q;
  assign map_px   = {map_x, map_y, map_color, map_plot};
  assign erase_px = {erase_x, erase_y, erase_color, erase_plot};
  assign draw_px  = {draw_x, draw_y, draw_color, draw_plot};

  vga_client_mux u_mux (
    .sel_i   (mux_sel),
    .map_i   (map_px),
    .erase_i (erase_px),
    .draw_i  (draw_px),
    .vga_o   (vga_px)
  );

  assign {vga_x, vga_y, vga_color, vga_plot} = vga_px;

  assign map_start    = map_start_q;
  assign erase_start  = erase_start_q;
  assign draw_start   = draw_start_q;
  assign update_pulse = update_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler: a phase-level timeline model predicts every
// cycle's control outputs and mux selection under randomized client latencies.
module tb_vga_frame_scheduler;

  localparam int FD    = 16;
  localparam int TO    = 8;
  localparam int MAXC  = 512;
  localparam int NF    = 64;
  localparam int NEVER = 100000;

  typedef enum int {P_IDLE, P_MAP, P_WAIT, P_ERASE, P_UPDATE, P_DRAW} phase_e;

  logic       clock_50 = 1'b0;
  logic       resetn = 1'b0, en = 1'b0;
  logic       map_start, erase_start, draw_start;
  logic       map_done = 1'b0, erase_done = 1'b0, draw_done = 1'b0;
  logic [7:0] map_x, map_y, erase_x, erase_y, draw_x, draw_y;
  logic [2:0] map_color, erase_color, draw_color;
  logic       map_plot, erase_plot, draw_plot;
  logic       update_pulse;
  logic [7:0] vga_x, vga_y;
  logic [2:0] vga_color;
  logic       vga_plot, busy, overrun, timeout_err;
`ifdef VGA_SCHED_OVERRUN_COUNT_EN
  logic [7:0] overrun_count;
`endif

  always #5 clock_50 = ~clock_50;

  vga_frame_scheduler #(.FRAME_DIV(FD), .TIMEOUT(TO), .CW(8)) dut (
    .clock_50(clock_50), .resetn(resetn), .en(en),
    .map_start(map_start), .erase_start(erase_start), .draw_start(draw_start),
    .map_done(map_done), .erase_done(erase_done), .draw_done(draw_done),
    .map_x(map_x), .map_y(map_y), .map_color(map_color), .map_plot(map_plot),
    .erase_x(erase_x), .erase_y(erase_y), .erase_color(erase_color), .erase_plot(erase_plot),
    .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color), .draw_plot(draw_plot),
    .update_pulse(update_pulse),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
`ifdef VGA_SCHED_OVERRUN_COUNT_EN
    , .overrun_count(overrun_count)
`endif
  );

  int     n_cmp = 0, n_bad = 0, cyc = 0;
  phase_e m_ph[MAXC];
  bit     m_start[MAXC];
  int     m_ovr;
  bit     m_to;
  int     lat_m, lat_e[NF], lat_d[NF];
  int     en_off, mode;
  bit     stray;
  int     n_es, n_ds, done_m_at, done_e_at, done_d_at;

  // A phase of latency lat occupies lat+1 cycles, or TO cycles when it times out.
  function automatic int place(phase_e p, int lat, int c, int n);
    int len;
    len = (lat > TO - 1) ? TO : lat + 1;
    if (lat > TO - 1 && c + len - 1 <= n - 1) m_to = 1'b1;
    for (int i = 0; i < len; i++)
      if (c + i <= n) begin
        m_ph[c + i]    = p;
        m_start[c + i] = (i == 0);
      end
    return c + len;
  endfunction

  // Cycle n after reset release has frame count n mod FD; tick when it is FD-1.
  task automatic build_model(input int n);
    int c, f;
    for (int i = 0; i < MAXC; i++) begin
      m_ph[i] = P_IDLE;
      m_start[i] = 1'b0;
    end
    m_ovr = 0;
    m_to  = 1'b0;
    f     = 0;
    c     = place(P_MAP, lat_m, 1, n);
    while (c <= n) begin
      while (c <= n && !((c % FD == FD - 1) && c < en_off)) begin
        m_ph[c] = P_WAIT;
        c++;
      end
      if (c > n) break;
      m_ph[c] = P_WAIT;
      c++;
      c = place(P_ERASE, lat_e[f % NF], c, n);
      if (c <= n) begin
        m_ph[c] = P_UPDATE;
        m_start[c] = 1'b0;
      end
      c++;
      c = place(P_DRAW, lat_d[f % NF], c, n);
      f++;
    end
    for (int i = 1; i < n; i++)
      if (m_ph[i] != P_WAIT && (i % FD == FD - 1)) m_ovr++;
  endtask

  task automatic drive_inputs(input phase_e p, input bit st);
    {map_x, map_y, map_color, map_plot}         = 20'($urandom);
    {erase_x, erase_y, erase_color, erase_plot} = 20'($urandom);
    {draw_x, draw_y, draw_color, draw_plot}     = 20'($urandom);
    if (mode == 1) begin
      erase_x    = 8'h2A;
      erase_plot = cyc[0];
      draw_plot  = 1'b1;
      map_plot   = 1'b1;
    end
    en         = (cyc < en_off);
    map_done   = (cyc == done_m_at) ||
                 (stray && (p != P_MAP || st) && $urandom_range(3) == 0);
    erase_done = (cyc == done_e_at) ||
                 (stray && (p != P_ERASE || st) && $urandom_range(3) == 0);
    draw_done  = (cyc == done_d_at) ||
                 (stray && (p != P_DRAW || st) && $urandom_range(3) == 0);
  endtask

  task automatic step();
    phase_e     p;
    bit         st;
    logic [4:0] exp_ctl, act_ctl;
    logic [19:0] exp_px, act_px;
    @(posedge clock_50);
    cyc++;
    @(negedge clock_50);
    p  = m_ph[cyc];
    st = m_start[cyc];
    if (map_start) done_m_at = cyc + lat_m;
    if (erase_start) begin
      done_e_at = cyc + lat_e[n_es % NF];
      n_es++;
    end
    if (draw_start) begin
      done_d_at = cyc + lat_d[n_ds % NF];
      n_ds++;
    end
    drive_inputs(p, st);
    #1;
    exp_ctl = {(p == P_MAP) && st, (p == P_ERASE) && st, (p == P_DRAW) && st,
               p == P_UPDATE, p != P_WAIT};
    act_ctl = {map_start, erase_start, draw_start, update_pulse, busy};
    n_cmp++;
    if (act_ctl !== exp_ctl) begin
      n_bad++;
      $display("FAIL ctl cyc=%0d phase=%s start/erase/draw/update/busy got=%b exp=%b",
               cyc, p.name(), act_ctl, exp_ctl);
    end
    case (p)
      P_MAP:   exp_px = {map_x, map_y, map_color, map_plot};
      P_ERASE: exp_px = {erase_x, erase_y, erase_color, erase_plot};
      P_DRAW:  exp_px = {draw_x, draw_y, draw_color, draw_plot};
      default: exp_px = '0;
    endcase
    act_px = {vga_x, vga_y, vga_color, vga_plot};
    n_cmp++;
    if (act_px !== exp_px) begin
      n_bad++;
      $display("FAIL mux cyc=%0d phase=%s got=%h exp=%h", cyc, p.name(), act_px, exp_px);
    end
  endtask

  // Reset is checked one edge after resetn falls, then released.
  task automatic do_reset();
    @(negedge clock_50);
    resetn = 1'b0;
    cyc    = 0;
    drive_inputs(P_IDLE, 1'b0);
    map_done = 1'b0; erase_done = 1'b0; draw_done = 1'b0;
    @(negedge clock_50);
    #1;
    n_cmp++;
    if ({map_start, erase_start, draw_start, update_pulse, vga_x, vga_y, vga_color,
         vga_plot, busy, overrun, timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got start=%b%b%b upd=%b vga=%h/%h/%h/%b busy=%b ovr=%b to=%b exp all 0",
               map_start, erase_start, draw_start, update_pulse, vga_x, vga_y, vga_color,
               vga_plot, busy, overrun, timeout_err);
    end
`ifdef VGA_SCHED_OVERRUN_COUNT_EN
    n_cmp++;
    if (overrun_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_overrun_count got=%0d exp=0", overrun_count);
    end
`endif
    @(negedge clock_50);
    resetn    = 1'b1;
    en        = (0 < en_off);
    done_m_at = -1; done_e_at = -1; done_d_at = -1;
    n_es      = 0;  n_ds      = 0;
  endtask

  task automatic run_cycles(input int n, input int stop_at);
    while (cyc < n && cyc != stop_at) step();
  endtask

  task automatic check_sticky(input string name);
    n_cmp++;
    if (overrun !== (m_ovr > 0) || timeout_err !== m_to) begin
      n_bad++;
      $display("FAIL %s sticky got overrun=%b timeout_err=%b exp %b %b",
               name, overrun, timeout_err, m_ovr > 0, m_to);
    end
`ifdef VGA_SCHED_OVERRUN_COUNT_EN
    n_cmp++;
    if (overrun_count !== 8'((m_ovr > 255) ? 255 : m_ovr)) begin
      n_bad++;
      $display("FAIL %s overrun_count got=%0d exp=%0d", name, overrun_count, m_ovr);
    end
`endif
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_m = $urandom_range(hi, lo);
    for (int i = 0; i < NF; i++) begin
      lat_e[i] = $urandom_range(hi, lo);
      lat_d[i] = $urandom_range(hi, lo);
    end
  endtask

  task automatic test_reset();
    set_lat(3, 3);
    lat_m = 5; en_off = 0; stray = 1'b0; mode = 0;
    build_model(40);
    do_reset();
    run_cycles(40, -1);
    check_sticky("reset");
  endtask

  task automatic test_frames();
    set_lat(1, 5);
    lat_e[0] = 3; lat_d[0] = 3; lat_m = 3;
    en_off = NEVER; stray = 1'b1; mode = 0;
    build_model(200);
    do_reset();
    run_cycles(200, -1);
    check_sticky("frames");
  endtask

  task automatic test_mux();
    set_lat(3, 3);
    en_off = NEVER; stray = 1'b0; mode = 1;
    build_model(60);
    do_reset();
    run_cycles(60, -1);
    mode = 0;
  endtask

  // Frame 0 hits done exactly on timer expiry (no error) and runs past the next tick.
  task automatic test_overrun_boundary();
    set_lat(5, 7);
    lat_e[0] = TO - 1; lat_d[0] = TO - 1;
    en_off = NEVER; stray = 1'b0;
    build_model(200);
    do_reset();
    run_cycles(200, -1);
    check_sticky("overrun");
  endtask

  task automatic test_timeout();
    set_lat(1, 4);
    lat_d[0] = NEVER;
    en_off = NEVER; stray = 1'b0;
    build_model(120);
    do_reset();
    run_cycles(120, -1);
    check_sticky("timeout");
  endtask

  task automatic test_reset_mid_draw();
    int stop_at;
    set_lat(3, 3);
    en_off = NEVER; stray = 1'b0;
    build_model(100);
    stop_at = 100;
    for (int i = 99; i >= 1; i--)
      if (m_ph[i] == P_DRAW && m_start[i]) stop_at = i + 2;
    do_reset();
    run_cycles(100, stop_at);
    build_model(80);
    do_reset();
    run_cycles(80, -1);
    check_sticky("reset_mid_draw");
  endtask

  task automatic test_en_drop();
    int first_erase;
    set_lat(3, 3);
    en_off = NEVER; stray = 1'b1;
    build_model(120);
    first_erase = 120;
    for (int i = 119; i >= 1; i--)
      if (m_ph[i] == P_ERASE && m_start[i]) first_erase = i;
    en_off = first_erase + 2;
    build_model(120);
    do_reset();
    run_cycles(120, -1);
    check_sticky("en_drop");
  endtask

  initial begin
    en_off = 0; mode = 0; stray = 1'b0;
    done_m_at = -1; done_e_at = -1; done_d_at = -1;
    n_es = 0; n_ds = 0;
    test_reset();
    test_frames();
    test_mux();
    test_overrun_boundary();
    test_timeout();
    test_reset_mid_draw();
    test_en_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "bench stalled");
  end

endmodule
